// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone B4 classic controller arbiter.
//   WB_ADR_W / WB_DAT_W : peripheral bus address and data widths
//   wb_arb_state_t      : arbiter FSM state encoding
//   WB_TIMEOUT_DAT      : read data returned to a controller whose cycle timed out
//   idx_width()         : bit width of a controller index for a given controller count
package wb_pkg;

    localparam int WB_ADR_W = 4;
    localparam int WB_DAT_W = 8;

    localparam logic [WB_DAT_W-1:0] WB_TIMEOUT_DAT = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wb_arb_state_t;

    // Width of an index into n controllers, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : one request bit per controller
//   last  : index of the controller served most recently
//   grant : first requester found searching last+1, last+2, ... (wrapping)
//   valid : at least one request is present
module rr_pick
    import wb_pkg::*;
#(
    parameter int NCTRL = 2,
    parameter int IDX_W = idx_width(NCTRL)
) (
    input  logic [NCTRL-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    int               pos_s;
    logic [IDX_W-1:0] idx_s;

    // Walk outward from last+1; the nearest requester in rotation order wins.
    always_comb begin
        grant = {IDX_W{1'b0}};
        valid = 1'b0;
        pos_s = 0;
        idx_s = {IDX_W{1'b0}};
        for (int i = 1; i <= NCTRL; i++) begin
            pos_s = (int'(last) + i) % NCTRL;
            idx_s = IDX_W'(pos_s);
            if (!valid && req[idx_s]) begin
                grant = idx_s;
                valid = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one Wishbone B4 classic peripheral bus (4-bit address,
// 8-bit data) between NCTRL controllers using round-robin arbitration.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   c_stb_i/c_we_i       per-controller strobe / write enable
//   c_adr_i/c_dat_i      per-controller address [4k+:4] / write data [8k+:8]
//   c_ack_o              per-controller ack (one-hot or zero)
//   c_dat_o              read data broadcast to all controllers
//   wb_stb_o/wb_we_o     peripheral strobe / write enable
//   wb_adr_o/wb_dat_o    peripheral address / write data
//   wb_ack_i/wb_dat_i    peripheral ack / read data
//
// Optional feature macro WB_ARBITER_TIMEOUT_EN: a watchdog terminates a cycle
// that has gone TIMEOUT BUSY cycles without ack, returning WB_TIMEOUT_DAT.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NCTRL   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NCTRL-1:0]          c_stb_i,
    input  logic [NCTRL-1:0]          c_we_i,
    input  logic [NCTRL*WB_ADR_W-1:0] c_adr_i,
    input  logic [NCTRL*WB_DAT_W-1:0] c_dat_i,
    output logic [NCTRL-1:0]          c_ack_o,
    output logic [WB_DAT_W-1:0]       c_dat_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [WB_ADR_W-1:0]       wb_adr_o,
    output logic [WB_DAT_W-1:0]       wb_dat_o,
    input  logic                      wb_ack_i,
    input  logic [WB_DAT_W-1:0]       wb_dat_i
);

    localparam int IDX_W = idx_width(NCTRL);

    wb_arb_state_t    state_r, state_nxt_s;
    logic [IDX_W-1:0] grant_r, grant_nxt_s;
    logic [IDX_W-1:0] last_r, last_nxt_s;
    logic [IDX_W-1:0] pick_grant_s;
    logic             pick_valid_s;
    logic             timeout_s;

    rr_pick #(
        .NCTRL (NCTRL),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (c_stb_i),
        .last  (last_r),
        .grant (pick_grant_s),
        .valid (pick_valid_s)
    );

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_r;

    // Watchdog: held at zero outside BUSY, counts BUSY cycles without ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != BUSY) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!wb_ack_i) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // BUSY cycle number TIMEOUT (count TIMEOUT-1) is the forced-termination cycle.
    assign timeout_s = (state_r == BUSY) && c_stb_i[grant_r] &&
                       (cnt_r == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State, grant and rotation pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            grant_r <= {IDX_W{1'b0}};
            last_r  <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, finish on ack, abort or timeout.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_nxt_s = pick_grant_s;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (wb_ack_i || !c_stb_i[grant_r] || timeout_s) begin
                    last_nxt_s  = grant_r;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bus mux from the granted controller; ack steered back only to it.
    always_comb begin
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = {WB_ADR_W{1'b0}};
        wb_dat_o = {WB_DAT_W{1'b0}};
        c_ack_o  = {NCTRL{1'b0}};
        if (state_r == BUSY) begin
            wb_stb_o         = c_stb_i[grant_r] & ~timeout_s;
            wb_we_o          = c_we_i[grant_r];
            wb_adr_o         = c_adr_i[int'(grant_r)*WB_ADR_W +: WB_ADR_W];
            wb_dat_o         = c_dat_i[int'(grant_r)*WB_DAT_W +: WB_DAT_W];
            c_ack_o[grant_r] = wb_ack_i | timeout_s;
        end else begin
            c_ack_o = {NCTRL{1'b0}};
        end
    end

    assign c_dat_o = timeout_s ? WB_TIMEOUT_DAT : wb_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with two controllers.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  c_stb;
    logic [1:0]  c_we;
    logic [7:0]  c_adr;
    logic [15:0] c_dat;
    logic [1:0]  c_ack;
    logic [7:0]  c_dat_rd;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_adr;
    logic [7:0]  wb_dat_wr;
    logic        wb_ack;
    logic [7:0]  wb_dat_rd;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter #(
        .NCTRL   (2),
        .TIMEOUT (16)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .c_stb_i  (c_stb),
        .c_we_i   (c_we),
        .c_adr_i  (c_adr),
        .c_dat_i  (c_dat),
        .c_ack_o  (c_ack),
        .c_dat_o  (c_dat_rd),
        .wb_stb_o (wb_stb),
        .wb_we_o  (wb_we),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_dat_wr),
        .wb_ack_i (wb_ack),
        .wb_dat_i (wb_dat_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_ack;
        logic [3:0] exp_adr;

        rst_n     = 1'b0;
        c_stb     = 2'b00;
        c_we      = 2'b00;
        c_adr     = 8'h00;
        c_dat     = 16'h0000;
        wb_ack    = 1'b0;
        wb_dat_rd = 8'h5A;

        // Reset state
        #12;
        chk("rst_stb", wb_stb, 1'b0);
        chk("rst_we", wb_we, 1'b0);
        chk("rst_adr", wb_adr, 4'h0);
        chk("rst_dat", wb_dat_wr, 8'h00);
        chk("rst_ack", c_ack, 2'b00);
        chk("rst_cdat", c_dat_rd, 8'h5A);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: single write from controller 0
        c_stb = 2'b01;
        c_we  = 2'b01;
        c_adr = 8'h03;
        c_dat = 16'h00A5;
        @(negedge clk);
        chk("t1_latency_stb", wb_stb, 1'b0);
        step();
        @(negedge clk);
        chk("t1_stb", wb_stb, 1'b1);
        chk("t1_adr", wb_adr, 4'h3);
        chk("t1_dat", wb_dat_wr, 8'hA5);
        chk("t1_we", wb_we, 1'b1);
        chk("t1_noack", c_ack, 2'b00);
        wb_ack = 1'b1;
        #1;
        chk("t1_ack", c_ack, 2'b01);
        step();
        wb_ack = 1'b0;
        c_stb  = 2'b00;
        @(negedge clk);
        chk("t1_idle_stb", wb_stb, 1'b0);
        chk("t1_idle_ack", c_ack, 2'b00);
        step();

        // 2: both requesting continuously, grants rotate 1,0,1,0
        c_stb = 2'b11;
        c_we  = 2'b00;
        c_adr = 8'h92;
        for (int r = 0; r < 4; r++) begin
            wb_ack = 1'b0;
            @(negedge clk);
            chk("t2_gap_stb", wb_stb, 1'b0);
            step();
            exp_ack = (r % 2 == 0) ? 2'b10 : 2'b01;
            exp_adr = (r % 2 == 0) ? 4'h9 : 4'h2;
            @(negedge clk);
            chk("t2_stb", wb_stb, 1'b1);
            chk("t2_adr", wb_adr, exp_adr);
            wb_ack = 1'b1;
            #1;
            chk("t2_ack", c_ack, exp_ack);
            step();
        end
        wb_ack = 1'b0;

        // 3: controller 1 reads adr 7, controller 0 pending
        c_adr = 8'h72;
        c_we  = 2'b01;
        @(negedge clk);
        chk("t3_gap_stb", wb_stb, 1'b0);
        step();
        @(negedge clk);
        chk("t3_adr", wb_adr, 4'h7);
        chk("t3_we", wb_we, 1'b0);
        wb_ack    = 1'b1;
        wb_dat_rd = 8'h3C;
        #1;
        chk("t3_cdat", c_dat_rd, 8'h3C);
        chk("t3_ack", c_ack, 2'b10);
        step();

        // 4: controller 0 granted, aborts after 2 BUSY cycles; controller 1 next
        wb_ack = 1'b0;
        c_adr  = 8'h92;
        @(negedge clk);
        chk("t4_idle_ack", c_ack, 2'b00);
        step();
        @(negedge clk);
        chk("t4_stb_c1", wb_stb, 1'b1);
        chk("t4_adr_c0", wb_adr, 4'h2);
        chk("t4_noack_c1", c_ack, 2'b00);
        step();
        @(negedge clk);
        chk("t4_stb_c2", wb_stb, 1'b1);
        step();
        c_stb = 2'b10;
        #1;
        chk("t4_abort_stb", wb_stb, 1'b0);
        chk("t4_abort_ack", c_ack, 2'b00);
        step();
        @(negedge clk);
        chk("t4_idle_stb", wb_stb, 1'b0);
        step();
        @(negedge clk);
        chk("t4_next_stb", wb_stb, 1'b1);
        chk("t4_next_adr", wb_adr, 4'h9);

        // 5: reset mid-cycle, then rotation restarts from last=0
        c_stb = 2'b11;
        #2;
        rst_n  = 1'b0;
        wb_ack = 1'b1;
        #1;
        chk("t5_rst_stb", wb_stb, 1'b0);
        chk("t5_rst_ack", c_ack, 2'b00);
        @(negedge clk);
        rst_n  = 1'b1;
        wb_ack = 1'b0;
        step();
        @(negedge clk);
        chk("t5_post_stb", wb_stb, 1'b1);
        chk("t5_post_adr", wb_adr, 4'h9);
        wb_ack = 1'b1;
        #1;
        chk("t5_post_ack", c_ack, 2'b10);
        step();
        wb_ack = 1'b0;

        // 6: no peripheral ack at all
        c_stb     = 2'b01;
        wb_dat_rd = 8'h11;
        @(negedge clk);
        chk("t6_gap_stb", wb_stb, 1'b0);
        step();
`ifdef WB_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("t6_wait_stb", wb_stb, 1'b1);
            chk("t6_wait_ack", c_ack, 2'b00);
            step();
        end
        @(negedge clk);
        chk("t6_to_ack", c_ack, 2'b01);
        chk("t6_to_cdat", c_dat_rd, 8'hFF);
        chk("t6_to_stb", wb_stb, 1'b0);
        step();
        c_stb = 2'b00;
        @(negedge clk);
        chk("t6_after_stb", wb_stb, 1'b0);
        chk("t6_after_ack", c_ack, 2'b00);
`else
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            chk("t6_hold_stb", wb_stb, 1'b1);
            chk("t6_hold_ack", c_ack, 2'b00);
            step();
        end
        chk("t6_hold_cdat", c_dat_rd, 8'h11);
        c_stb = 2'b00;
        #1;
        chk("t6_abort_stb", wb_stb, 1'b0);
        step();
        @(negedge clk);
        chk("t6_idle_stb", wb_stb, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
